// File: rtl/shift_result_stage.sv
// Result capture stage after the barrel shifter: 2-entry skid buffer with flag
// cleanup, valid/ready handoff to writeback, CVNZ status and a commit counter.
module shift_result_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_y,
  input  logic          in_c,
  input  logic [4:0]    in_shamt,
  input  logic [RW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_y,
  output logic [RW-1:0] out_rd,
  output logic          out_c,
  output logic          out_v,
  output logic          out_n,
  output logic          out_z,
  output logic [3:0]    status_cvnz,
  output logic [CW-1:0] shift_count
);

  typedef struct packed {
    logic [DW-1:0] y;
    logic [RW-1:0] rd;
    logic          c;
    logic          v;
    logic          n;
    logic          z;
  } ent_t;

  ent_t       mem [2];
  ent_t       hd, nxt;
  logic       head, tail;
  logic [1:0] count;
  logic       acc, pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // A known-zero select keeps an undriven carry from leaking into the entry.
  always_comb begin
    nxt    = '0;
    nxt.y  = in_y;
    nxt.rd = in_rd;
    nxt.c  = (in_shamt == 5'd0) ? 1'b0 : in_c;
    nxt.v  = 1'b0;
    nxt.n  = in_y[DW-1];
    nxt.z  = (in_y == '0);
  end

  always_comb begin
    hd = '0;
    if (count != 2'd0) hd = mem[head];
  end

  assign out_y  = hd.y;
  assign out_rd = hd.rd;
  assign out_c  = hd.c;
  assign out_v  = hd.v;
  assign out_n  = hd.n;
  assign out_z  = hd.z;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count       <= 2'd0;
      head        <= 1'b0;
      tail        <= 1'b0;
      status_cvnz <= 4'b0000;
      shift_count <= '0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      // Writeback has already taken the head, so a pop commits even under flush.
      if (pop) begin
        status_cvnz <= {hd.c, hd.v, hd.n, hd.z};
        shift_count <= shift_count + 1'b1;
      end
      if (flush) begin
        count <= 2'd0;
        head  <= 1'b0;
        tail  <= 1'b0;
      end else begin
        if (acc) begin
          mem[tail] <= nxt;
          tail      <= ~tail;
        end
        if (pop) head <= ~head;
        count <= count + 2'(acc) - 2'(pop);
      end
    end
  end

endmodule
